// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/response bundle between a shift requester and the sequencer
interface shift_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   shamt;
  logic             flush;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, a, shamt, flush,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, op, a, shamt, flush,
    output ready, busy, done, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle shifter: one 1-bit step per clock, SLL/SRL/SRA/ROR
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] work_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] result_q;
  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] step_w;

  function automatic logic [WIDTH-1:0] step(input logic [1:0] o, input logic [WIDTH-1:0] w);
    case (o)
      OP_SLL:  step = {w[WIDTH-2:0], 1'b0};
      OP_SRL:  step = {1'b0, w[WIDTH-1:1]};
      OP_SRA:  step = {w[WIDTH-1], w[WIDTH-1:1]};
      default: step = {w[0], w[WIDTH-1:1]};
    endcase
  endfunction

  // flush wins over start so an abort request can never be mistaken for a new job
  assign accept    = (state_q == IDLE) && bus.start && !bus.flush;
  assign last_step = (cnt_q == SHW'(1));
  assign step_w    = step(op_q, work_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (bus.shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (last_step) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // result only moves on entry to DONE; it holds through IDLE and the next job's SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      work_q   <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else if (accept) begin
      work_q <= bus.a;
      op_q   <= bus.op;
      cnt_q  <= bus.shamt;
      if (bus.shamt == '0) begin
        result_q <= bus.a;
      end
    end else if (state_q == SHIFT) begin
      if (bus.flush) begin
        cnt_q <= '0;
      end else begin
        work_q <= step_w;
        cnt_q  <= cnt_q - SHW'(1);
        if (last_step) begin
          result_q <= step_w;
        end
      end
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.busy   = (state_q == SHIFT);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed vector table plus hand sequences for shift_sequencer
module tb_shift_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  shift_sequencer_if #(.WIDTH(16), .SHW(4)) bus ();

  shift_sequencer #(.WIDTH(16), .SHW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [3:0]  sh;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue one job from IDLE and follow it until the sequencer is ready again
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [3:0] sh,
                        output int bc, output int dc, output logic [15:0] res);
    bus.op    = op;
    bus.a     = a;
    bus.shamt = sh;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bc  = 0;
    dc  = 0;
    res = 16'hxxxx;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) bc++;
      if (bus.done) begin
        dc++;
        res = bus.result;
      end
      if (bus.ready && dc > 0) break;
      tick();
    end
  endtask

  initial begin
    int bc, dc;
    logic [15:0] res;

    vecs[0]  = '{2'b10, 16'h8000, 4'd4,  16'hF800};
    vecs[1]  = '{2'b01, 16'h8000, 4'd4,  16'h0800};
    vecs[2]  = '{2'b00, 16'h0001, 4'd15, 16'h8000};
    vecs[3]  = '{2'b10, 16'd40,   4'd9,  16'h0000};
    vecs[4]  = '{2'b11, 16'h0001, 4'd1,  16'h8000};
    vecs[5]  = '{2'b11, 16'h1234, 4'd0,  16'h1234};
    vecs[6]  = '{2'b11, 16'h1234, 4'd4,  16'h4123};
    vecs[7]  = '{2'b00, 16'h00FF, 4'd4,  16'h0FF0};
    vecs[8]  = '{2'b10, 16'hF000, 4'd15, 16'hFFFF};
    vecs[9]  = '{2'b01, 16'hFFFF, 4'd15, 16'h0001};
    vecs[10] = '{2'b11, 16'h8001, 4'd15, 16'h0003};
    vecs[11] = '{2'b10, 16'h7FFF, 4'd3,  16'h0FFF};

    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 16'h0000;
    bus.shamt = 4'd0;

    #12;
    check("rst_ready",  bus.ready,  1);
    check("rst_busy",   bus.busy,   0);
    check("rst_done",   bus.done,   0);
    check("rst_result", bus.result, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].sh, bc, dc, res);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].sh);
      check($sformatf("vec%0d_done_count", i), dc, 1);
      check($sformatf("vec%0d_result_hold", i), bus.result, vecs[i].exp);
    end

    // start held high through SHIFT/DONE with different operands must not queue or disturb
    bus.op = 2'b10; bus.a = 16'h8000; bus.shamt = 4'd4; bus.start = 1'b1;
    tick();
    bus.op = 2'b00; bus.a = 16'hAAAA; bus.shamt = 4'd1;
    check("busy_result_hold", bus.result, 16'h0FFF);
    bc = 0; dc = 0; res = 16'hxxxx;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy) bc++;
      if (bus.done) begin
        dc++;
        res = bus.result;
      end
      if (bus.ready) begin
        bus.start = 1'b0;
        break;
      end
      tick();
    end
    check("ignore_result", res, 16'hF800);
    check("ignore_done_count", dc, 1);
    check("ignore_busy_cycles", bc, 4);
    tick();
    check("ignore_no_accept", bus.ready, 1);

    // flush in the second SHIFT cycle of an 8-step job
    bus.op = 2'b00; bus.a = 16'h0001; bus.shamt = 4'd8; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("flush_pre_busy", bus.busy, 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_ready",  bus.ready,  1);
    check("flush_busy",   bus.busy,   0);
    check("flush_done",   bus.done,   0);
    check("flush_result", bus.result, 16'hF800);
    dc = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) dc++;
      tick();
    end
    check("flush_no_done", dc, 0);

    // flush beats start in IDLE
    bus.flush = 1'b1; bus.start = 1'b1; bus.a = 16'h1234; bus.shamt = 4'd0;
    tick();
    check("idle_flush_ready",  bus.ready,  1);
    check("idle_flush_done",   bus.done,   0);
    check("idle_flush_result", bus.result, 16'hF800);
    bus.flush = 1'b0; bus.start = 1'b0;

    // flush while in DONE leaves the pulse intact
    bus.op = 2'b01; bus.a = 16'h00F0; bus.shamt = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b1;
    check("done_flush_done",   bus.done,   1);
    check("done_flush_result", bus.result, 16'h00F0);
    tick();
    bus.flush = 1'b0;
    check("done_flush_ready", bus.ready, 1);
    check("done_flush_after", bus.done,  0);

    // asynchronous reset mid-shift, then immediate accept after release
    bus.op = 2'b10; bus.a = 16'h8000; bus.shamt = 4'd8; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready",  bus.ready,  1);
    check("arst_busy",   bus.busy,   0);
    check("arst_done",   bus.done,   0);
    check("arst_result", bus.result, 0);
    #1;
    rst_n = 1'b1;
    run_op(2'b11, 16'h0001, 4'd1, bc, dc, res);
    check("post_rst_result", res, 16'h8000);
    check("post_rst_done_count", dc, 1);
    check("post_rst_busy_cycles", bc, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
